// File: rtl/sync_to_async_push.sv
// Clocked valid/ready to 4-phase bundled-data bridge feeding the Muller pipeline.
// Words are buffered in a small FIFO and issued one handshake at a time using a synchronised ack.
module sync_to_async_push #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     async_req,
   output logic [WIDTH-1:0]         async_data,
   input  logic                     async_ack,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic                     proto_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count, count_next;
   logic             push, pop;

   logic load, req_rise, req_fall, err_set;

   // async_ack is only ever used after this chain; nothing else looks at the raw input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], async_ack};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   assign push = in_valid && in_ready;
   assign pop  = load;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // in_ready is precomputed from the next count so it is a plain flop output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count    <= count_next;
         in_ready <= (count_next != (AW+1)'(DEPTH));
      end
   end

   assign fifo_count = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!ack_s && (count != '0)) state_next = SETUP;
         SETUP:   state_next = WAIT_HI;
         WAIT_HI: if (ack_s) state_next = WAIT_LO;
         WAIT_LO: if (!ack_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load     = (state == IDLE) && !ack_s && (count != '0);
      req_rise = (state == SETUP);
      req_fall = (state == WAIT_HI) && ack_s;
      err_set  = (state == IDLE) && ack_s;
      busy     = (state != IDLE);
   end

   // Data is captured one cycle ahead of req so the bundle has a full cycle of setup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         async_req  <= 1'b0;
         async_data <= '0;
         proto_err  <= 1'b0;
      end else begin
         if (load) begin
            async_data <= mem[rd_ptr];
         end
         if (req_rise) begin
            async_req <= 1'b1;
         end else if (req_fall) begin
            async_req <= 1'b0;
         end
         if (err_set) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sync_to_async_push.sv
// Scoreboard bench for sync_to_async_push: stimulus queues expected words, a monitor checks
// each word as async_req rises, with a delayed-ack responder emulating the Muller stage.
module tb_sync_to_async_push;

   localparam int WIDTH       = 8;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 500;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             async_req;
   logic [WIDTH-1:0] async_data;
   logic             async_ack;
   logic [2:0]       fifo_count;
   logic             busy;
   logic             proto_err;

   logic resp_en;
   logic resp_ack;
   logic force_ack;

   int vec_count = 0;
   int err_count = 0;

   logic [WIDTH-1:0] exp_q [$];

   assign async_ack = resp_ack | force_ack;

   sync_to_async_push #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .async_req(async_req),
      .async_data(async_data),
      .async_ack(async_ack),
      .fifo_count(fifo_count),
      .busy(busy),
      .proto_err(proto_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Push one word, waiting for in_ready; returns on the negedge after the accepting edge
   task automatic applyStimulus(input logic [WIDTH-1:0] word);
      int n;
      n = 0;
      while (!in_ready && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checkOutput("push_timeout", {31'b0, in_ready}, 32'd1);
      end else begin
         in_valid = 1'b1;
         in_data  = word;
         exp_q.push_back(word);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while ((busy || fifo_count != 3'd0 || exp_q.size() != 0) && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {31'b0, !(busy || fifo_count != 3'd0 || exp_q.size() != 0)}, 32'd1);
   endtask

   // Stage responder: ack follows req after three clocks in each direction
   initial begin : responder
      int dly;
      resp_ack = 1'b0;
      dly = 0;
      forever begin
         @(negedge clk);
         if (!resp_en || !rst_n) begin
            resp_ack = 1'b0;
            dly = 0;
         end else if (async_req != resp_ack) begin
            dly++;
            if (dly == 3) begin
               resp_ack = async_req;
               dly = 0;
            end
         end else begin
            dly = 0;
         end
      end
   end

   // Monitor: on each req rise, check bundling setup and delivery order; hold data while req is high
   logic             prev_req = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   logic [WIDTH-1:0] held_data = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (async_req && !prev_req) begin
            checkOutput("data_setup", {24'b0, async_data}, {24'b0, prev_data});
            if (exp_q.size() == 0) begin
               vec_count++;
               err_count++;
               $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word at %0t", async_data, $time);
            end else begin
               checkOutput("data_order", {24'b0, async_data}, {24'b0, exp_q.pop_front()});
            end
            held_data = async_data;
         end else if (async_req) begin
            checkOutput("data_hold", {24'b0, async_data}, {24'b0, held_data});
         end
         prev_req = async_req;
      end
      prev_data = async_data;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      resp_en   = 1'b0;
      force_ack = 1'b0;

      // Reset with random inputs toggling
      repeat (4) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         force_ack = 1'($urandom_range(0, 1));
         checkOutput("rst_req", {31'b0, async_req}, 32'd0);
         checkOutput("rst_data", {24'b0, async_data}, 32'd0);
         checkOutput("rst_count", {29'b0, fifo_count}, 32'd0);
         checkOutput("rst_ready", {31'b0, in_ready}, 32'd0);
         checkOutput("rst_busy", {31'b0, busy}, 32'd0);
         checkOutput("rst_err", {31'b0, proto_err}, 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_data   = '0;
      force_ack = 1'b0;
      rst_n     = 1'b1;
      checkOutput("ready_before_edge", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      checkOutput("ready_after_release", {31'b0, in_ready}, 32'd1);

      // Single word with responder active
      resp_en = 1'b1;
      applyStimulus(8'hA5);
      checkOutput("single_count", {29'b0, fifo_count}, 32'd1);
      waitIdle("single_drain");
      checkOutput("single_busy", {31'b0, busy}, 32'd0);
      checkOutput("single_req", {31'b0, async_req}, 32'd0);

      // Fill with responder stalled: one word in flight, four buffered
      resp_en = 1'b0;
      for (int w = 1; w <= 5; w++) begin
         applyStimulus(8'(w));
      end
      checkOutput("fill_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("fill_count", {29'b0, fifo_count}, 32'd4);
      checkOutput("fill_req", {31'b0, async_req}, 32'd1);
      in_valid = 1'b1;
      in_data  = 8'h06;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checkOutput("held_off_count", {29'b0, fifo_count}, 32'd4);
      checkOutput("held_off_ready", {31'b0, in_ready}, 32'd0);
      resp_en = 1'b1;
      applyStimulus(8'h06);
      waitIdle("fill_drain");

      // Push on the same edge as a pop with two words buffered
      resp_en = 1'b0;
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      checkOutput("pp_count_pre", {29'b0, fifo_count}, 32'd2);
      resp_en = 1'b1;
      n = 0;
      while (busy && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      checkOutput("pp_reach_idle", {31'b0, busy}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h44;
      exp_q.push_back(8'h44);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("pp_count_post", {29'b0, fifo_count}, 32'd2);
      checkOutput("pp_busy", {31'b0, busy}, 32'd1);
      waitIdle("pp_drain");

      // Reset while waiting for ack high
      resp_en = 1'b0;
      applyStimulus(8'h5A);
      n = 0;
      while (!async_req && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mid_req_high", {31'b0, async_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_req_drop", {31'b0, async_req}, 32'd0);
      checkOutput("mid_data", {24'b0, async_data}, 32'd0);
      checkOutput("mid_busy", {31'b0, busy}, 32'd0);
      checkOutput("mid_count", {29'b0, fifo_count}, 32'd0);
      checkOutput("mid_ready", {31'b0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("mid_post_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("mid_post_count", {29'b0, fifo_count}, 32'd0);
      resp_en = 1'b1;
      applyStimulus(8'h3C);
      waitIdle("mid_restart");

      // Ack high while idle with a word waiting
      resp_en   = 1'b0;
      force_ack = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(8'h77);
      repeat (4) @(negedge clk);
      checkOutput("perr_busy", {31'b0, busy}, 32'd0);
      checkOutput("perr_count", {29'b0, fifo_count}, 32'd1);
      checkOutput("perr_req", {31'b0, async_req}, 32'd0);
      checkOutput("perr_flag", {31'b0, proto_err}, 32'd1);
      force_ack = 1'b0;
      resp_en   = 1'b1;
      waitIdle("perr_resume");
      applyStimulus(8'h99);
      waitIdle("perr_traffic");
      checkOutput("perr_sticky", {31'b0, proto_err}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("perr_cleared", {31'b0, proto_err}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
